// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX stage and the multi-cycle divider.
// The EX stage drives the master side; the divider presents the slave side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 annul;
    logic                 div_stall;
    logic                 ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_div, a, b, annul,
        input  div_stall, ready, result
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output div_stall, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle, result {HI, LO}.
//   state   | meaning
//   IDLE    | waiting for start; operands latched on acceptance
//   DIVZERO | divisor was zero; result = {a, all ones}, ready pulses
//   BUSY    | iterating one quotient bit per cycle, pipeline stalled
//   DONE    | sign-corrected result valid, ready pulses
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} stateType;

    stateType             state;
    stateType             nextState;
    logic [CW-1:0]        count;
    logic [2*WIDTH:0]     shiftReg;
    logic [WIDTH-1:0]     divisor;
    logic                 qNeg;
    logic                 rNeg;
    logic [2*WIDTH-1:0]   resultReg;

    logic                 accept;
    logic                 bZero;
    logic [WIDTH-1:0]     aMag;
    logic [WIDTH-1:0]     bMag;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH+1:0]     diff;
    logic [2*WIDTH:0]     stepSr;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quoFix;
    logic [WIDTH-1:0]     remFix;

    assign accept = (state == IDLE) && bus.start && !bus.annul;
    assign bZero  = (bus.b == '0);
    assign aMag   = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign bMag   = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One restoring step; the final step feeds the result register directly.
    always_comb begin
        shifted = shiftReg << 1;
        diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
        if (!diff[WIDTH+1]) begin
            stepSr = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            stepSr = shifted;
        end
        quo    = stepSr[WIDTH-1:0];
        rem    = stepSr[2*WIDTH-1:WIDTH];
        quoFix = qNeg ? -quo : quo;
        remFix = rNeg ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    nextState = bZero ? DIVZERO : BUSY;
                end
            end
            BUSY: begin
                if (bus.annul) begin
                    nextState = IDLE;
                end else if (count == LAST_COUNT) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            DIVZERO: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.div_stall = (accept && !bZero) || (state == BUSY);
        bus.ready     = (state == DONE) || (state == DIVZERO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            shiftReg  <= '0;
            divisor   <= '0;
            qNeg      <= 1'b0;
            rNeg      <= 1'b0;
            resultReg <= '0;
        end else if (accept) begin
            if (bZero) begin
                resultReg <= {bus.a, {WIDTH{1'b1}}};
            end else begin
                shiftReg <= {{(WIDTH+1){1'b0}}, aMag};
                divisor  <= bMag;
                qNeg     <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                rNeg     <= bus.signed_div && bus.a[WIDTH-1];
                count    <= '0;
            end
        end else if ((state == BUSY) && !bus.annul) begin
            shiftReg <= stepSr;
            count    <= count + 1'b1;
            if (count == LAST_COUNT) begin
                resultReg <= {remFix, quoFix};
            end
        end
    end

    assign bus.result = resultReg;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: per-cycle stall/latency checks plus a result scoreboard.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [63:0] sbQ[$];
    logic [63:0] lastRes = '0;
    logic        prevReady = 1'b0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] refDiv(input logic sd, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (!sd) return {x % y, x / y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Scoreboard consumer: every ready pulse must match the oldest outstanding expectation.
    always begin
        @(negedge clk);
        #2;
        if (bus.ready) begin
            checkEq("ready_not_back_to_back", {63'd0, prevReady}, 64'd0);
            if (sbQ.size() == 0) begin
                checkEq("spurious_ready", {63'd0, bus.ready}, 64'd0);
            end else begin
                lastRes = sbQ.pop_front();
                checkEq("result", bus.result, lastRes);
            end
        end
        prevReady = bus.ready;
    end

    task automatic runOp(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] expRes, input int ignCyc, input int annCyc,
                         input int rstCyc);
        int lat;
        bit done;
        int expLat;
        expLat = (bv != 0) ? 33 : 1;
        done   = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.a          = av;
        bus.b          = bv;
        sbQ.push_back(expRes);
        #1;
        checkEq("stall_at_start", {63'd0, bus.div_stall}, {63'd0, (bv != 0)});
        @(negedge clk);
        for (lat = 1; lat <= 40; lat++) begin
            bus.start = (lat == ignCyc);
            bus.a     = $urandom;
            bus.b     = $urandom_range(1, 1000);
            bus.annul = (lat == annCyc);
            if (lat == annCyc) void'(sbQ.pop_back());
            if (lat == rstCyc) begin
                rst = 1'b1;
                #1;
                checkEq("rst_ready", {63'd0, bus.ready}, 64'd0);
                checkEq("rst_stall", {63'd0, bus.div_stall}, 64'd0);
                checkEq("rst_result", bus.result, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                sbQ.delete();
                lastRes = '0;
                done = 1'b1;
                break;
            end
            #1;
            if (annCyc >= 0 && lat == annCyc + 1) begin
                checkEq("annul_stall_low", {63'd0, bus.div_stall}, 64'd0);
                checkEq("annul_no_ready", {63'd0, bus.ready}, 64'd0);
                checkEq("annul_result_kept", bus.result, lastRes);
                done = 1'b1;
                break;
            end
            if (bus.ready) break;
            checkEq("stall_busy", {63'd0, bus.div_stall}, {63'd0, (bv != 0)});
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.annul = 1'b0;
        if (!done) begin
            checkEq("latency", 64'(lat), 64'(expLat));
            checkEq("stall_at_ready", {63'd0, bus.div_stall}, 64'd0);
        end
    endtask

    initial begin
        logic        sd;
        logic [31:0] ra, rb;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkEq("reset_ready", {63'd0, bus.ready}, 64'd0);
        checkEq("reset_stall", {63'd0, bus.div_stall}, 64'd0);
        checkEq("reset_result", bus.result, 64'd0);
        rst = 1'b0;

        runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, -1, -1, -1);
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, -1, -1);
        runOp(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, -1, -1, -1);
        runOp(1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, -1, -1, -1);
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1, -1, -1);
        runOp(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, -1, -1, -1);

        runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, -1, 10, -1);
        runOp(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, -1, -1, -1);

        runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 5, -1, -1);
        runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, -1, -1, 15);

        // annul in IDLE must beat start
        @(negedge clk);
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd3;
        #1;
        checkEq("idle_annul_stall", {63'd0, bus.div_stall}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        #1;
        checkEq("idle_annul_no_ready", {63'd0, bus.ready}, 64'd0);
        checkEq("idle_annul_result", bus.result, 64'd0);

        for (int i = 0; i < 16; i++) begin
            sd = i[0];
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 255);
                2: rb = (i == 6) ? 32'd0 : ~($urandom_range(0, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            runOp(sd, ra, rb, refDiv(sd, ra, rb), -1, -1, -1);
        end

        repeat (3) @(negedge clk);
        checkEq("scoreboard_drained", 64'(sbQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit signed/unsigned divider for the execute stage of the five-stage MIPS pipeline. Serves DIV/DIVU: takes operands from EX when the instruction enters it, iterates one quotient bit per cycle, and drives the `div_stall` signal that freezes the decode/execute pipeline registers and the control pipeline while it runs. Writes {remainder, quotient} for HI/LO.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  the EX-stage instruction is DIV/DIVU; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a`  in  WIDTH  dividend (rs); sampled with `start`.
- `b`  in  WIDTH  divisor (rt); sampled with `start`.
- `annul`  in  1  flush/exception kill; aborts an operation in progress.
- `div_stall`  out  1  pipeline stall request.
- `ready`  out  1  one-cycle pulse: `result` is valid and must be written to HI/LO.
- `result`  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]} = {HI, LO}.

## Operation
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE: if `start` & ~`annul`, latch operands and sign mode. If `b`==0, go to DIVZERO. Otherwise go to BUSY with counter=0.
- Signed mode: the magnitudes |a| and |b| are latched as WIDTH-bit unsigned values. Sign flags are also latched: q_neg = a[MSB]^b[MSB] and r_neg = a[MSB].
- BUSY: restoring radix-2 algorithm with a (2*WIDTH+1)-bit partial remainder/quotient shift register.
  - Each cycle: shift left 1 and trial-subtract the divisor from the upper half.
  - If the difference is non-negative, keep it and set quotient bit 1; otherwise set quotient bit 0.
  - The counter increments. When the counter reaches WIDTH-1, go to DONE.
- DONE: `result` is registered.
  - Quotient is negated if q_neg; remainder is negated if r_neg.
  - `ready`=1 for this cycle, then the block returns to IDLE.
- DIVZERO: `result` = {a, {WIDTH{1'b1}}}, `ready`=1 for one cycle, then IDLE. Not trapped.
- Overflow case (signed, a=0x80000000, b=0xFFFFFFFF): natural result of the magnitude algorithm, quotient=0x80000000, remainder=0. No special path.
- `result` holds its last value until the next `ready`.
- `start` in BUSY, DONE or DIVZERO is ignored.
- `annul`:
  - In BUSY: next state IDLE, no `ready`, `result` unchanged.
  - In IDLE: wins over `start`; the operation does not begin.
  - In DONE or DIVZERO: `ready` still pulses. The writeback qualification is the consumer's job.

## Timing
- Reset values: state=IDLE, counter=0, `result`=0, `ready`=0, `div_stall`=0. Assertion of `rst` at any point, mid-operation included, returns the block to these values immediately.
- `div_stall` is combinational and high when either of these holds:
  - state IDLE & `start` & ~`annul` & `b`!=0;
  - state BUSY.
- `div_stall` is low in DONE, DIVZERO and IDLE otherwise. Releasing the stall in DONE lets EX advance on the same edge that `ready`/`result` are consumed.
- Latency, nonzero divisor: `start` accepted at edge 0; BUSY occupies cycles 1..32; DONE (`ready`=1) in cycle 33. Stall is high for 33 cycles (0..32).
- Latency, zero divisor: `start` accepted in cycle 0; DIVZERO in cycle 1 with `ready`=1. No stall.
- Back-to-back operation: a new `start` is accepted in the first IDLE cycle after DONE, i.e. 34 cycles after the previous start at minimum.
- `ready` is never high for two consecutive cycles.

## Test plan
- Unsigned: `start`, `signed_div`=0, a=100, b=7 -> `div_stall` high in cycles 0..32; `ready` in cycle 33; `result`={0x00000002, 0x0000000E}.
- Signed negatives: a=0xFFFFFFF9 (-7), b=2, `signed_div`=1 -> `result`={0xFFFFFFFF, 0xFFFFFFFD} (r=-1, q=-3). Then a=7, b=0xFFFFFFFE -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero: a=0x12345678, b=0 -> `div_stall` never high; `ready` in cycle 1; `result`={0x12345678, 0xFFFFFFFF}.
- Overflow and unsigned max: signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- Annul mid-operation: start 100/7, assert `annul` in cycle 10 -> `div_stall` low from cycle 11. No `ready`, and the previous `result` is retained. A fresh start in cycle 12 completes with `ready` in cycle 45.
- Reset and ignored start: assert `rst` in cycle 15 -> all outputs 0 at once. Separately, pulse `start` in cycle 5 of a busy operation with different operands -> ignored; the original result is returned in cycle 33.
